// File: rtl/uart_pkg.sv
// Shared definitions for the UART block link: controller state encoding,
// default byte/block geometry and the byte-counter width helper.
package uart_pkg;

  localparam int DBITS_DEF       = 8;
  localparam int BLOCK_BYTES_DEF = 16;
  localparam int BLOCK_W         = DBITS_DEF * BLOCK_BYTES_DEF;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    PRESENT  = 2'd1,
    WAIT_RES = 2'd2,
    SEND     = 2'd3
  } link_state_t;

  // Counter wide enough to hold 0..nbytes-1 with one bit of headroom.
  function automatic int cnt_width(input int nbytes);
    return $clog2(nbytes) + 1;
  endfunction

endpackage

// File: rtl/uart_byte_shifter.sv
// Parallel-load / serial-shift register organised as NBYTES bytes of DBITS.
// Bytes enter at the LSB end and leave from the MSB end, so the first byte
// shifted in ends up in the MSB position after NBYTES shifts. A byte counter
// tracks shifts and wraps to zero after the last one; 'last' flags that the
// next shift completes the block.
module uart_byte_shifter
  import uart_pkg::*;
#(
  parameter int DBITS  = DBITS_DEF,
  parameter int NBYTES = BLOCK_BYTES_DEF,
  localparam int W     = DBITS * NBYTES,
  localparam int CW    = cnt_width(NBYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             shift,
  input  logic [DBITS-1:0] shift_in,
  output logic [W-1:0]     data,
  output logic [CW-1:0]    count,
  output logic             last
);

  assign last = (count == CW'(NBYTES - 1));

  // Clear beats load beats shift; a shift on the last byte wraps the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift) begin
      data  <= {data[W-DBITS-1:0], shift_in};
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_block_link.sv
// Host-side controller between the UART FIFOs and a wide block datapath.
// Packs BLOCK_BYTES received bytes into one block (first byte in the MSB),
// hands it to the core over valid/ready, accepts the core's result over a
// second valid/ready pair and pushes it back out MSB byte first.
// Optional inter-byte timeout: define UART_BLOCK_TIMEOUT_EN to build a gap
// counter that discards a stalled partial block and pulses sync_err.
module uart_block_link
  import uart_pkg::*;
#(
  parameter int DBITS          = DBITS_DEF,
  parameter int BLOCK_BYTES    = BLOCK_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic                         rx_empty,
  input  logic [DBITS-1:0]             read_data,
  output logic                         read_uart,
  input  logic                         tx_full,
  output logic [DBITS-1:0]             write_data,
  output logic                         write_uart,
  output logic [BLOCK_BYTES*DBITS-1:0] blk_in_data,
  output logic                         blk_in_valid,
  input  logic                         blk_in_ready,
  input  logic [BLOCK_BYTES*DBITS-1:0] blk_out_data,
  input  logic                         blk_out_valid,
  output logic                         blk_out_ready,
  output logic                         busy,
  output logic                         sync_err
);

  localparam int W  = DBITS * BLOCK_BYTES;
  localparam int CW = cnt_width(BLOCK_BYTES);

  link_state_t     state;
  logic [W-1:0]    rx_data;
  logic [W-1:0]    tx_data;
  logic [CW-1:0]   rx_count;
  logic [CW-1:0]   tx_count;
  logic            rx_last;
  logic            tx_last;
  logic            pop;
  logic            push;
  logic            tx_load;
  logic            timeout_hit;
  logic            unused_bits;

  // Pops are gated by reset so the FIFO is never drained while we are held.
  assign pop        = !reset && (state == COLLECT) && !rx_empty;
  assign push       = (state == SEND) && !tx_full;
  assign tx_load    = (state == WAIT_RES) && blk_out_valid;

  assign read_uart   = pop;
  assign write_uart  = push;
  assign write_data  = (state == SEND) ? tx_data[W-1 -: DBITS] : '0;
  assign blk_in_data = rx_data;
  assign busy        = !((state == COLLECT) && (rx_count == '0));

  // The Tx counter and the low Tx bytes are internal bookkeeping only.
  assign unused_bits = ^{tx_data[W-DBITS-1:0], tx_count};

  uart_byte_shifter #(
    .DBITS  (DBITS),
    .NBYTES (BLOCK_BYTES)
  ) u_rx_pack (
    .clk       (clk_100MHz),
    .rst       (reset),
    .clear     (timeout_hit),
    .load      (1'b0),
    .load_data ('0),
    .shift     (pop),
    .shift_in  (read_data),
    .data      (rx_data),
    .count     (rx_count),
    .last      (rx_last)
  );

  uart_byte_shifter #(
    .DBITS  (DBITS),
    .NBYTES (BLOCK_BYTES)
  ) u_tx_unpack (
    .clk       (clk_100MHz),
    .rst       (reset),
    .clear     (1'b0),
    .load      (tx_load),
    .load_data (blk_out_data),
    .shift     (push),
    .shift_in  ('0),
    .data      (tx_data),
    .count     (tx_count),
    .last      (tx_last)
  );

  // Block-level sequencing with registered handshake outputs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state         <= COLLECT;
      blk_in_valid  <= 1'b0;
      blk_out_ready <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (pop && rx_last) begin
            state        <= PRESENT;
            blk_in_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (blk_in_ready) begin
            state         <= WAIT_RES;
            blk_in_valid  <= 1'b0;
            blk_out_ready <= 1'b1;
          end
        end
        WAIT_RES: begin
          if (blk_out_valid) begin
            state         <= SEND;
            blk_out_ready <= 1'b0;
          end
        end
        SEND: begin
          if (push && tx_last) begin
            state <= COLLECT;
          end
        end
        default: begin
          state         <= COLLECT;
          blk_in_valid  <= 1'b0;
          blk_out_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_BLOCK_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [GW-1:0] gap_cnt;

  assign timeout_hit = (state == COLLECT) && !pop && (rx_count != '0) &&
                       (gap_cnt == GW'(TIMEOUT_CYCLES - 1));

  // Gap counter runs only while a partial block waits for its next byte.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      gap_cnt  <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= timeout_hit;
      if ((state != COLLECT) || pop || (rx_count == '0) || timeout_hit) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign sync_err    = 1'b0;
`endif

endmodule

// File: doc/uart_block_link.md
Name: uart_block_link

Overview:
- Host-side controller for the UART core. It is the reader of the Rx FIFO and the writer of the Tx FIFO.
- Pops received bytes and packs BLOCK_BYTES of them into one wide block. Hands the block to a processing core over a valid/ready handshake.
- Accepts the core's wide result over a second valid/ready handshake and serialises it back, byte by byte, into the Tx FIFO.
- Sits between uart_top's FIFO ports and the 128-bit datapath core.

Parameters:
- DBITS, 8, bits per UART byte (must match the UART core).
- BLOCK_BYTES, 16, bytes per block; block width is BLOCK_BYTES*DBITS.
- TIMEOUT_CYCLES, 2000000, inter-byte gap limit in clock cycles (20 ms at 100 MHz); used only with UART_BLOCK_TIMEOUT_EN.

Ports:
- clk_100MHz  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_empty  in  1  Rx FIFO empty.
- read_data  in  DBITS  Rx FIFO head word; valid whenever rx_empty=0.
- read_uart  out  1  Rx FIFO pop strobe.
- tx_full  in  1  Tx FIFO full.
- write_data  out  DBITS  byte pushed to the Tx FIFO.
- write_uart  out  1  Tx FIFO push strobe.
- blk_in_data  out  BLOCK_BYTES*DBITS  assembled block to the core.
- blk_in_valid  out  1  block valid.
- blk_in_ready  in  1  core accepts the block.
- blk_out_data  in  BLOCK_BYTES*DBITS  result from the core.
- blk_out_valid  in  1  result valid.
- blk_out_ready  out  1  controller accepts the result.
- busy  out  1  high in every state except COLLECT with byte count 0.
- sync_err  out  1  one-cycle pulse when a partial block is discarded.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=COLLECT, byte count=0, and every register cleared. Reset values of all outputs: read_uart=0, write_uart=0, write_data=0, blk_in_data=0, blk_in_valid=0, blk_out_ready=0, busy=0, sync_err=0.
- Reset mid-operation discards any partial block or partial transmission with no further output.
- COLLECT:
  - read_uart = !rx_empty, combinational. No other state ever asserts read_uart.
  - On each edge with read_uart=1: shift register <= {shift[W-DBITS-1:0], read_data}, count++. The first byte received ends up in the MSB byte of the block.
  - Back-to-back pops on consecutive cycles are legal; the FIFO's registered empty flag prevents over-read.
  - When a pop occurs with count==BLOCK_BYTES-1: count wraps to 0, state -> PRESENT, and blk_in_valid=1 on the next cycle.
- PRESENT:
  - blk_in_data is stable and blk_in_valid is held high until the handshake.
  - On an edge with blk_in_valid && blk_in_ready: blk_in_valid=0, state -> WAIT_RES.
  - No Rx pops in this state; incoming bytes accumulate in the Rx FIFO.
- WAIT_RES:
  - blk_out_ready=1.
  - On an edge with blk_out_valid=1: load blk_out_data into the Tx shift register, count=0, state -> SEND. blk_out_ready drops on that same edge.
- SEND:
  - write_data = MSB byte of the Tx shift register.
  - write_uart = !tx_full, combinational.
  - On each edge with write_uart=1: shift left by DBITS and count++.
  - After the BLOCK_BYTES-th push: count=0, state -> COLLECT.
  - While tx_full is high, the state is held and no bytes are dropped.
- Latency: last Rx pop -> blk_in_valid = 1 cycle. Result handshake -> first write_uart = 1 cycle (given tx_full=0). Full block out = BLOCK_BYTES cycles when the Tx FIFO is never full.
- Byte counter width is $clog2(BLOCK_BYTES)+1; it never exceeds BLOCK_BYTES-1.

Optional Feature:
- Macro: UART_BLOCK_TIMEOUT_EN.
- With the macro defined:
  - A gap counter runs in COLLECT whenever count!=0. It clears on every pop.
  - When the gap counter reaches TIMEOUT_CYCLES: shift register and count are cleared, and sync_err pulses high for 1 cycle.
  - The gap counter is idle in all other states.
- Without the macro: no gap counter is built, sync_err is tied to 0, and partial blocks wait indefinitely.

Decomposition:
- Shared package uart_pkg holds: the state enum (COLLECT, PRESENT, WAIT_RES, SEND), the DBITS/BLOCK_BYTES defaults, and the BLOCK_W localparam.
- One sub-module is natural: uart_byte_shifter, a parameterised parallel-load/serial-shift register with a counter and a "last" flag. It is instantiated twice: once for Rx packing and once for Tx unpacking.

Test Plan:
- Push bytes 0x00..0x0F into the Rx FIFO model -> exactly 16 read_uart pulses; blk_in_data=0x000102030405060708090A0B0C0D0E0F; blk_in_valid rises 1 cycle after the last pop.
- Hold blk_in_ready=0 for 5 cycles, then 1 -> blk_in_valid and blk_in_data stable for all 5 cycles; valid falls the cycle after the handshake; no read_uart pulses during PRESENT even with rx_empty=0.
- Drive blk_out_data=0xA0A1...AF with blk_out_valid=1 -> write_data sequence A0,A1,...,AF across 16 write_uart pulses on consecutive cycles, then return to COLLECT.
- Assert tx_full for 4 cycles after the 3rd Tx byte -> no write_uart pulses while full; the sequence resumes at 0xA3 with no byte lost or duplicated.
- Assert reset after 7 Rx bytes, then feed 16 bytes 0x10..0x1F -> blk_in_data=0x101112...1F; all outputs read 0 while reset is high.
- With UART_BLOCK_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 5 bytes, idle 100 cycles -> one sync_err pulse; the next 16 bytes form a clean block. Without the macro, sync_err stays 0.
